// File: rtl/npu_pkg.sv
// npu_pkg: shared scheduler state encoding, default widths and phase-selection helper.
package npu_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int INV_W_DEF = 16;

   typedef enum logic [2:0] {
      SCHED_IDLE,
      SCHED_READ,
      SCHED_COMPUTE,
      SCHED_WRITE,
      SCHED_DONE
   } sched_state_t;

   // First phase that still has work, in READ/COMPUTE/WRITE order.
   function automatic sched_state_t next_phase(input logic rd, input logic cmp, input logic wr);
      return rd ? SCHED_READ : cmp ? SCHED_COMPUTE : wr ? SCHED_WRITE : SCHED_DONE;
   endfunction

endpackage

// File: rtl/npu_sched_counter.sv
// npu_sched_counter: loadable down-counter with enable, clear and zero/last flags.
module npu_sched_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero,
   output logic         o_last
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_en && r_count != '0)
         r_count <= r_count - W'(1);
   end

   assign o_zero = r_count == '0;
   assign o_last = r_count == W'(1);

endmodule

// File: rtl/npu_scheduler.sv
// npu_scheduler: sequences one NPU invocation (read inputs, compute wait, write outputs)
// and drives the FIFO strobes consumed by npu_state_machine.
module npu_scheduler
   import npu_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int INV_W = INV_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             sched_cfg_load,
   input  logic [CNT_W-1:0] sched_cfg_num_inputs,
   input  logic [CNT_W-1:0] sched_cfg_compute_cycles,
   input  logic [CNT_W-1:0] sched_cfg_num_outputs,
   input  logic             sched_start,
   input  logic             sched_abort,
   input  logic             npu_state_config,
   input  logic             npu_state_stall,
   input  logic             npu_input_fifo_empty,
   input  logic             npu_output_fifo_full,
   output logic             npu_sched_input_fifo_read_en,
   output logic             npu_sched_output_fifo_write_en,
   output logic             sched_busy,
   output logic             sched_done,
   output logic [INV_W-1:0] sched_invocations
);

   sched_state_t     r_state, w_next;
   logic [CNT_W-1:0] r_cfg_in, r_cfg_cmp, r_cfg_out;
   logic [INV_W-1:0] r_inv;
   logic             w_idle, w_start, w_abort, w_rd, w_wr, w_cmp_en;
   logic             w_in_zero, w_in_last, w_cmp_zero, w_cmp_last, w_out_zero, w_out_last;

   assign w_idle   = r_state == SCHED_IDLE;
   assign w_start  = w_idle & sched_start & !npu_state_config;
   assign w_abort  = !w_idle & sched_abort;
   assign w_cmp_en = (r_state == SCHED_COMPUTE) & !npu_state_stall;

   npu_sched_counter #(.W(CNT_W)) u_in_cnt (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_clr      (w_abort),
      .i_load     (w_start),
      .i_load_val (r_cfg_in),
      .i_en       (w_rd),
      .o_zero     (w_in_zero),
      .o_last     (w_in_last)
   );

   npu_sched_counter #(.W(CNT_W)) u_cmp_cnt (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_clr      (w_abort),
      .i_load     (w_start),
      .i_load_val (r_cfg_cmp),
      .i_en       (w_cmp_en),
      .o_zero     (w_cmp_zero),
      .o_last     (w_cmp_last)
   );

   npu_sched_counter #(.W(CNT_W)) u_out_cnt (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_clr      (w_abort),
      .i_load     (w_start),
      .i_load_val (r_cfg_out),
      .i_en       (w_wr),
      .o_zero     (w_out_zero),
      .o_last     (w_out_last)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= SCHED_IDLE;
         r_cfg_in  <= '0;
         r_cfg_cmp <= '0;
         r_cfg_out <= '0;
         r_inv     <= '0;
      end else begin
         r_state <= w_next;
         if (w_idle && sched_cfg_load) begin
            r_cfg_in  <= sched_cfg_num_inputs;
            r_cfg_cmp <= sched_cfg_compute_cycles;
            r_cfg_out <= sched_cfg_num_outputs;
         end
         if (r_state == SCHED_DONE && !sched_abort)
            r_inv <= r_inv + INV_W'(1);
      end
   end

   // Start decides its first phase from the cfg regs because the counters load on the same edge.
   always_comb begin
      w_next = r_state;
      case (r_state)
         SCHED_IDLE:
            if (w_start)
               w_next = next_phase(r_cfg_in != '0, r_cfg_cmp != '0, r_cfg_out != '0);
         SCHED_READ:
            if (w_in_zero || (w_rd && w_in_last))
               w_next = next_phase(1'b0, !w_cmp_zero, !w_out_zero);
         SCHED_COMPUTE:
            if (w_cmp_zero || (w_cmp_en && w_cmp_last))
               w_next = next_phase(1'b0, 1'b0, !w_out_zero);
         SCHED_WRITE:
            if (w_out_zero || (w_wr && w_out_last))
               w_next = SCHED_DONE;
         default:
            w_next = SCHED_IDLE;
      endcase
      if (w_abort)
         w_next = SCHED_IDLE;
   end

   always_comb begin
      w_rd = (r_state == SCHED_READ) & !npu_input_fifo_empty & !npu_state_stall & !sched_abort;
      w_wr = (r_state == SCHED_WRITE) & !npu_output_fifo_full & !npu_state_stall & !sched_abort;
      npu_sched_input_fifo_read_en   = w_rd;
      npu_sched_output_fifo_write_en = w_wr;
      sched_busy                     = !w_idle;
      sched_done                     = (r_state == SCHED_DONE) & !sched_abort;
      sched_invocations              = r_inv;
   end

endmodule
